// File: rtl/wb_regfile.sv
// Writeback stage for the RV32IF pipeline: selects the writeback values, commits them to the
// integer and FP register files, serves the decode read ports with same-cycle bypass, and counts retires.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_enable_wb,
    input  logic [4:0]       rd_wb,
    input  logic             ld_wb,
    input  logic [XLEN-1:0]  mem_data,
    input  logic [XLEN-1:0]  result_out,
    input  logic             fwb_enable_wb,
    input  logic [4:0]       frd_wb,
    input  logic             fld_wb,
    input  logic [XLEN-1:0]  mem_data_out_f_wb,
    input  logic [XLEN-1:0]  fresult_out,
    input  logic             retire_valid,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic [4:0]       frs1_addr,
    input  logic [4:0]       frs2_addr,
    input  logic [4:0]       frs3_addr,
    output logic [XLEN-1:0]  frs1_data,
    output logic [XLEN-1:0]  frs2_data,
    output logic [XLEN-1:0]  frs3_data,
    output logic [XLEN-1:0]  wb_data_fwd,
    output logic [XLEN-1:0]  fwb_data_fwd,
    output logic [CNT_W-1:0] instret
);

    logic [XLEN-1:0]  r_xregs [32];
    logic [XLEN-1:0]  r_fregs [32];
    logic [CNT_W-1:0] r_instret;

    logic [XLEN-1:0]  w_wb_data;
    logic [XLEN-1:0]  w_fwb_data;
    logic             w_int_we;
    logic             w_fp_we;

    // Read-port rule shared by every port; zero_x0 enables the hardwired-zero x0 behaviour.
    function automatic logic [XLEN-1:0] read_port(
        input logic            rst_ok,
        input logic            zero_x0,
        input logic [4:0]      raddr,
        input logic            we,
        input logic [4:0]      waddr,
        input logic [XLEN-1:0] wdata,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] v;
        if (!rst_ok) begin
            v = {XLEN{1'b0}};
        end else if (zero_x0 && (raddr == 5'd0)) begin
            v = {XLEN{1'b0}};
        end else if (we && (raddr == waddr)) begin
            v = wdata;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Writeback value selection and commit qualification.
    always_comb begin
        w_wb_data  = ld_wb  ? mem_data          : result_out;
        w_fwb_data = fld_wb ? mem_data_out_f_wb : fresult_out;
        w_int_we   = wb_enable_wb && (rd_wb != 5'd0);
        w_fp_we    = fwb_enable_wb;
    end

    // Integer register file; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_xregs[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (w_int_we) begin
                r_xregs[rd_wb] <= w_wb_data;
            end
        end
    end

    // FP register file; f0 is an ordinary register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_fregs[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (w_fp_we) begin
                r_fregs[frd_wb] <= w_fwb_data;
            end
        end
    end

    // Retired-instruction counter, wraps naturally at full scale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instret <= {CNT_W{1'b0}};
        end else if (retire_valid) begin
            r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_instret <= r_instret;
        end
    end

    // Combinational read ports with write bypass, suppressed while in reset.
    always_comb begin
        rs1_data  = read_port(rst, 1'b1, rs1_addr,  w_int_we, rd_wb,  w_wb_data,  r_xregs[rs1_addr]);
        rs2_data  = read_port(rst, 1'b1, rs2_addr,  w_int_we, rd_wb,  w_wb_data,  r_xregs[rs2_addr]);
        frs1_data = read_port(rst, 1'b0, frs1_addr, w_fp_we,  frd_wb, w_fwb_data, r_fregs[frs1_addr]);
        frs2_data = read_port(rst, 1'b0, frs2_addr, w_fp_we,  frd_wb, w_fwb_data, r_fregs[frs2_addr]);
        frs3_data = read_port(rst, 1'b0, frs3_addr, w_fp_we,  frd_wb, w_fwb_data, r_fregs[frs3_addr]);
    end

    assign wb_data_fwd  = w_wb_data;
    assign fwb_data_fwd = w_fwb_data;
    assign instret      = r_instret;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed stimulus queues expected port values,
// a monitor process samples the DUT on the falling edge and compares.
module tb_wb_regfile;

    localparam int XLEN  = 32;
    localparam int CNT_W = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wb_enable_wb = 1'b0;
    logic [4:0]       rd_wb = 5'd0;
    logic             ld_wb = 1'b0;
    logic [XLEN-1:0]  mem_data = 32'h0;
    logic [XLEN-1:0]  result_out = 32'h0;
    logic             fwb_enable_wb = 1'b0;
    logic [4:0]       frd_wb = 5'd0;
    logic             fld_wb = 1'b0;
    logic [XLEN-1:0]  mem_data_out_f_wb = 32'h0;
    logic [XLEN-1:0]  fresult_out = 32'h0;
    logic             retire_valid = 1'b0;
    logic [4:0]       rs1_addr = 5'd0;
    logic [4:0]       rs2_addr = 5'd0;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [4:0]       frs1_addr = 5'd0;
    logic [4:0]       frs2_addr = 5'd0;
    logic [4:0]       frs3_addr = 5'd0;
    logic [XLEN-1:0]  frs1_data;
    logic [XLEN-1:0]  frs2_data;
    logic [XLEN-1:0]  frs3_data;
    logic [XLEN-1:0]  wb_data_fwd;
    logic [XLEN-1:0]  fwb_data_fwd;
    logic [CNT_W-1:0] instret;

    wb_regfile #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .wb_enable_wb(wb_enable_wb), .rd_wb(rd_wb), .ld_wb(ld_wb),
        .mem_data(mem_data), .result_out(result_out),
        .fwb_enable_wb(fwb_enable_wb), .frd_wb(frd_wb), .fld_wb(fld_wb),
        .mem_data_out_f_wb(mem_data_out_f_wb), .fresult_out(fresult_out),
        .retire_valid(retire_valid),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .frs1_addr(frs1_addr), .frs2_addr(frs2_addr), .frs3_addr(frs3_addr),
        .frs1_data(frs1_data), .frs2_data(frs2_data), .frs3_data(frs3_data),
        .wb_data_fwd(wb_data_fwd), .fwb_data_fwd(fwb_data_fwd),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef enum int {P_RS1, P_RS2, P_FRS1, P_FRS2, P_FRS3, P_WBF, P_FWBF, P_CNT} port_e;
    typedef struct {
        string       name;
        port_e       port;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_val(input string name, input port_e port, input logic [63:0] exp);
        exp_t e;
        e.name = name;
        e.port = port;
        e.exp  = exp;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sample(input port_e p);
        logic [63:0] v;
        case (p)
            P_RS1:   v = {32'h0, rs1_data};
            P_RS2:   v = {32'h0, rs2_data};
            P_FRS1:  v = {32'h0, frs1_data};
            P_FRS2:  v = {32'h0, frs2_data};
            P_FRS3:  v = {32'h0, frs3_data};
            P_WBF:   v = {32'h0, wb_data_fwd};
            P_FWBF:  v = {32'h0, fwb_data_fwd};
            P_CNT:   v = instret;
            default: v = 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
        return v;
    endfunction

    // Monitor: drain all expectations queued for this cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                logic [63:0] act;
                e   = q.pop_front();
                act = sample(e.port);
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        // Reset with a write and a retire pending; neither may take effect.
        #2;
        rst          = 1'b0;
        wb_enable_wb = 1'b1;
        rd_wb        = 5'd5;
        result_out   = 32'hDEADBEEF;
        retire_valid = 1'b1;
        rs1_addr     = 5'd5;
        step();
        step();
        expect_val("reset_rs1_bypass_off", P_RS1, 64'h0);
        expect_val("reset_instret", P_CNT, 64'h0);
        expect_val("reset_wbfwd", P_WBF, 64'hDEADBEEF);
        step();
        rst          = 1'b1;
        wb_enable_wb = 1'b0;
        retire_valid = 1'b0;
        expect_val("post_reset_x5", P_RS1, 64'h0);
        expect_val("post_reset_instret", P_CNT, 64'h0);

        // Load-data path with bypass, then from storage.
        step();
        wb_enable_wb = 1'b1; rd_wb = 5'd7; ld_wb = 1'b1;
        mem_data = 32'h12345678; result_out = 32'hAAAA0000;
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        expect_val("lw_bypass_rs1", P_RS1, 64'h12345678);
        expect_val("lw_bypass_rs2", P_RS2, 64'h12345678);
        step();
        wb_enable_wb = 1'b0;
        expect_val("lw_stored_rs1", P_RS1, 64'h12345678);
        expect_val("lw_stored_rs2", P_RS2, 64'h12345678);
        // ALU-result path.
        step();
        wb_enable_wb = 1'b1; ld_wb = 1'b0;
        expect_val("alu_bypass_rs1", P_RS1, 64'hAAAA0000);
        expect_val("alu_bypass_rs2", P_RS2, 64'hAAAA0000);
        step();
        wb_enable_wb = 1'b0;
        expect_val("alu_stored_rs1", P_RS1, 64'hAAAA0000);
        expect_val("alu_stored_rs2", P_RS2, 64'hAAAA0000);

        // x0 protection.
        step();
        wb_enable_wb = 1'b1; rd_wb = 5'd0; result_out = 32'hFFFFFFFF; rs1_addr = 5'd0;
        expect_val("x0_same_cycle", P_RS1, 64'h0);
        expect_val("x0_wbfwd", P_WBF, 64'hFFFFFFFF);
        step();
        wb_enable_wb = 1'b0;
        expect_val("x0_after", P_RS1, 64'h0);

        // Concurrent integer and FP writes, f0 writable.
        step();
        wb_enable_wb = 1'b1; rd_wb = 5'd3; ld_wb = 1'b0; result_out = 32'h11;
        fwb_enable_wb = 1'b1; frd_wb = 5'd0; fld_wb = 1'b1;
        mem_data_out_f_wb = 32'h3F800000; fresult_out = 32'h0;
        rs2_addr = 5'd3; frs1_addr = 5'd0; frs2_addr = 5'd0; frs3_addr = 5'd0;
        expect_val("int_x3_bypass", P_RS2, 64'h11);
        expect_val("f0_bypass_frs1", P_FRS1, 64'h3F800000);
        expect_val("f0_bypass_frs2", P_FRS2, 64'h3F800000);
        expect_val("f0_bypass_frs3", P_FRS3, 64'h3F800000);
        expect_val("fwbfwd_flw", P_FWBF, 64'h3F800000);
        step();
        wb_enable_wb = 1'b0; fwb_enable_wb = 1'b0; fld_wb = 1'b0;
        expect_val("int_x3_stored", P_RS2, 64'h11);
        expect_val("f0_stored_frs1", P_FRS1, 64'h3F800000);
        expect_val("f0_stored_frs2", P_FRS2, 64'h3F800000);
        expect_val("f0_stored_frs3", P_FRS3, 64'h3F800000);
        expect_val("fwbfwd_fres", P_FWBF, 64'h0);

        // Retire counter: ten pulses separated by idle cycles.
        for (int i = 0; i < 20; i++) begin
            step();
            retire_valid = ((i % 2) == 0);
        end
        step();
        retire_valid = 1'b0;
        expect_val("instret_ten", P_CNT, 64'd10);

        // Wrap from full scale.
        step();
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        retire_valid = 1'b1;
        expect_val("instret_preload", P_CNT, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        retire_valid = 1'b0;
        expect_val("instret_wrap", P_CNT, 64'h0);

        // Mid-stream reset while streaming writes to f9.
        step();
        fwb_enable_wb = 1'b1; frd_wb = 5'd9; fld_wb = 1'b0; fresult_out = 32'h100;
        frs1_addr = 5'd9; rs1_addr = 5'd7; retire_valid = 1'b1;
        expect_val("f9_stream_a", P_FRS1, 64'h100);
        step();
        fresult_out = 32'h101;
        expect_val("f9_stream_b", P_FRS1, 64'h101);
        step();
        fresult_out = 32'h102;
        #1;
        rst = 1'b0;
        expect_val("f9_reset_now", P_FRS1, 64'h0);
        expect_val("x7_reset_now", P_RS1, 64'h0);
        expect_val("instret_reset_now", P_CNT, 64'h0);
        step();
        fresult_out = 32'h103;
        expect_val("f9_in_reset", P_FRS1, 64'h0);
        step();
        rst = 1'b1; fwb_enable_wb = 1'b0; retire_valid = 1'b0;
        expect_val("f9_after_release", P_FRS1, 64'h0);
        expect_val("x7_after_release", P_RS1, 64'h0);
        step();
        fwb_enable_wb = 1'b1; fresult_out = 32'h200;
        expect_val("f9_next_write", P_FRS1, 64'h200);
        step();
        fwb_enable_wb = 1'b0;
        expect_val("f9_next_stored", P_FRS1, 64'h200);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register files for the RV32IF pipeline, directly downstream of the memory stage. It consumes the memory stage's registered outputs, selects the writeback value for the integer and floating-point destinations, and commits it to a 32×32 integer file (x0 hardwired to zero) and a 32×32 FP file. It serves all decode-stage read ports with same-cycle write bypass and keeps a 64-bit retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, data width of both register files
- CNT_W, 64, width of the retired-instruction counter

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- wb_enable_wb  in  1  integer write enable from the memory stage
- rd_wb  in  5  integer destination index
- ld_wb  in  1  1 selects mem_data (LW), 0 selects result_out
- mem_data  in  XLEN  integer load data
- result_out  in  XLEN  ALU result
- fwb_enable_wb  in  1  FP write enable
- frd_wb  in  5  FP destination index
- fld_wb  in  1  1 selects mem_data_out_f_wb (FLW), 0 selects fresult_out
- mem_data_out_f_wb  in  XLEN  FP load data
- fresult_out  in  XLEN  FP unit result
- retire_valid  in  1  one instruction retires this cycle
- rs1_addr, rs2_addr  in  5 each  integer read indices
- rs1_data, rs2_data  out  XLEN each  integer read data (combinational)
- frs1_addr, frs2_addr, frs3_addr  in  5 each  FP read indices (frs3 serves fused multiply-add)
- frs1_data, frs2_data, frs3_data  out  XLEN each  FP read data (combinational)
- wb_data_fwd  out  XLEN  integer value being written this cycle, for EX forwarding
- fwb_data_fwd  out  XLEN  FP value being written this cycle
- instret  out  CNT_W  retired-instruction count

## Operation
- Integer write value: ld_wb ? mem_data : result_out. The write commits at posedge when wb_enable_wb=1, rst=1 and rd_wb≠0.
- FP write value: fld_wb ? mem_data_out_f_wb : fresult_out. The write commits when fwb_enable_wb=1 and rst=1. f0 is a normal, writable register.
- Integer and FP writes in the same cycle are independent and both commit.
- Integer read ports:
  - Address 0 returns 0.
  - If a write is enabled this cycle to the same nonzero address, the port returns the incoming write value (bypass).
  - Otherwise the port returns the stored value.
- FP read ports: same rule, without the x0 exception.
- Any number of read ports may alias one another or the write address. All return the same value.
- wb_data_fwd and fwb_data_fwd always show the selected mux value, independent of the enable. Consumers qualify them with wb_enable_wb / fwb_enable_wb.
- instret increments by 1 on each posedge with retire_valid=1. It wraps from 2^64−1 to 0.

## Timing
- Reset (rst=0, asynchronous):
  - All 64 registers clear to 0 and instret clears to 0.
  - Bypass is suppressed, so every read port returns 0 for the whole reset period.
  - Writes and retire_valid are ignored.
- Deassertion of rst takes effect at the next posedge. The first write can commit on that edge.
- A value written in cycle N is visible on read ports in cycle N (bypass) and from storage in cycle N+1 onward. Effective read-after-write latency is 0.
- Read ports are purely combinational from the address, the write inputs and storage. They have no register stage.
- Reset asserted in the middle of a stream clears state immediately. The write pending in that cycle is lost.

## Test plan
- Reset state: assert rst=0 with wb_enable_wb=1, rd_wb=5, result_out=0xDEADBEEF, then release. Required: rs1_addr=5 reads 0, instret=0, and no write occurred during reset.
- Integer mux and bypass: cycle N, wb_enable_wb=1, rd_wb=7, ld_wb=1, mem_data=0x12345678, result_out=0xAAAA0000, rs1_addr=rs2_addr=7. Required: both ports read 0x12345678 in cycle N and in N+1 with enable low. Repeat with ld_wb=0; required: 0xAAAA0000.
- x0 protection: write 0xFFFFFFFF to rd_wb=0. Required: rs1_data=0 for rs1_addr=0 in the same cycle and after; wb_data_fwd=0xFFFFFFFF.
- FP path and concurrent writes: same cycle, int write x3=0x11 and FP write f0=0x3F800000 via fld_wb=1. Required: rs2_addr=3 reads 0x11; frs1/frs2/frs3 all at address 0 read 0x3F800000 in both cycles.
- Retire counter: pulse retire_valid for 10 cycles with gaps. Required: instret=10. Preload the counter via force to 0xFFFFFFFF_FFFFFFFF and retire 1. Required: instret=0.
- Mid-stream reset: while writing f9 every cycle, drop rst between edges. Required: frs1_data for address 9 reads 0 immediately and stays 0 after release until the next write.
